// File: rtl/z80_vram_arbiter.sv
// Arbitrates one synchronous single-port VRAM between the Z80 bus and the video fetcher.
// Video normally wins; a starve counter forces a CPU slot after MAXWAIT denied cycles.
module z80_vram_arbiter #(
  parameter int AW      = 11,
  parameter int MAXWAIT = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [15:0]   cpu_adr,
  input  logic          cpu_mx,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic          cpu_cs,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_wait_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_adr,
  output logic          vid_ack,
  output logic [7:0]    vid_data,
  output logic [AW-1:0] ram_adr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);

  localparam int SW = $clog2(MAXWAIT + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAXWAIT);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] VID  = 3'd1;
  localparam logic [2:0] CRD  = 3'd2;
  localparam logic [2:0] CWR  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [2:0] RDL  = 3'd5;

  logic [2:0]    state;
  logic [SW-1:0] starve;
  logic          served;
  logic          vid_rd;
  logic          cpu_pend;
  logic          cpu_busy;
  logic          vid_ok;
  logic          cpu_first;
  logic          unused_adr;

  assign unused_adr = ^cpu_adr[15:AW];

  // reset_n gates pend so WAIT_n releases immediately while reset is held
  always_comb begin
    cpu_pend   = reset_n & cpu_mx & cpu_cs & (cpu_rd | cpu_wr) & ~served;
    cpu_wait_n = ~cpu_pend;
    cpu_busy   = (state == CRD) || (state == CWR) || (state == RDL);
    // vid_req stays high through its own read latency and ack cycle; don't re-grant it
    vid_ok     = vid_req & ~vid_rd & ~vid_ack;
    cpu_first  = cpu_pend & ((starve >= SMAX) | ~vid_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      starve    <= '0;
      served    <= 1'b0;
      vid_rd    <= 1'b0;
      vid_ack   <= 1'b0;
      vid_data  <= '0;
      cpu_din   <= '0;
      ram_adr   <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      vid_rd  <= (state == VID);
      vid_ack <= vid_rd;
      if (vid_rd) vid_data <= ram_rdata;
      ram_we <= 1'b0;

      case (state)
        IDLE: begin
          if (cpu_first) begin
            ram_adr <= cpu_adr[AW-1:0];
            if (cpu_wr) begin
              ram_we    <= 1'b1;
              ram_wdata <= cpu_dout;
              state     <= CWR;
            end else begin
              state <= CRD;
            end
          end else if (vid_ok) begin
            ram_adr <= vid_adr;
            state   <= VID;
          end
        end
        VID:  state <= IDLE;
        CRD:  state <= RDL;
        RDL: begin
          cpu_din <= ram_rdata;
          state   <= DONE;
        end
        CWR:  state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!cpu_mx) served <= 1'b0;
      else if (state == RDL || state == CWR) served <= 1'b1;

      if (state == IDLE && cpu_first) starve <= '0;
      else if (cpu_pend && !cpu_busy && starve < SMAX) starve <= starve + 1'b1;
    end
  end

endmodule

// File: tb/tb_z80_vram_arbiter.sv
// Directed bench for z80_vram_arbiter with a behavioural synchronous VRAM model.
module tb_z80_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_adr;
  logic        cpu_mx, cpu_rd, cpu_wr, cpu_cs;
  logic [7:0]  cpu_dout, cpu_din;
  logic        cpu_wait_n;
  logic        vid_req;
  logic [10:0] vid_adr;
  logic        vid_ack;
  logic [7:0]  vid_data;
  logic [10:0] ram_adr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;

  logic [7:0]  mem [0:2047];
  int          n_chk = 0;
  int          n_pass = 0;
  int          wr_cnt = 0;
  int          ack_cnt = 0;

  always #5 clk = ~clk;

  z80_vram_arbiter #(.AW(11), .MAXWAIT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_adr(cpu_adr), .cpu_mx(cpu_mx), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_cs(cpu_cs), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_wait_n(cpu_wait_n),
    .vid_req(vid_req), .vid_adr(vid_adr), .vid_ack(vid_ack), .vid_data(vid_data),
    .ram_adr(ram_adr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_adr] <= ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (vid_ack) ack_cnt <= ack_cnt + 1;
    ram_rdata <= mem[ram_adr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_mx = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_cs = 1'b0;
  endtask

  // Read with no video contention: stall in cycle 0, CRD in cycle 1, data + release in cycle 3
  task automatic cpu_read(input string tag, input logic [15:0] adr, input logic [7:0] exp);
    cpu_adr = adr; cpu_mx = 1'b1; cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0;
    #1 check({tag, "_wait_c0"}, cpu_wait_n, 0);
    tick();
    check({tag, "_adr_c1"}, ram_adr, 32'(adr[10:0]));
    check({tag, "_we_c1"}, ram_we, 0);
    tick();
    check({tag, "_wait_c2"}, cpu_wait_n, 0);
    tick();
    check({tag, "_wait_c3"}, cpu_wait_n, 1);
    check({tag, "_din_c3"}, cpu_din, 32'(exp));
    cpu_idle();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h123] = 8'hA5;
    mem[11'h010] = 8'h11;
    mem[11'h020] = 8'h22;
    mem[11'h030] = 8'h33;
    cpu_adr = '0; cpu_dout = '0; cpu_idle();
    vid_req = 1'b0; vid_adr = '0;
    reset_n = 1'b0;
    #1;
    check("rst_wait", cpu_wait_n, 1);
    check("rst_din", cpu_din, 0);
    check("rst_ack", vid_ack, 0);
    check("rst_vdata", vid_data, 0);
    check("rst_adr", ram_adr, 0);
    check("rst_we", ram_we, 0);
    check("rst_wdata", ram_wdata, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    cpu_read("rd123", 16'h0123, 8'hA5);

    // Write with rd also high (treated as write); upper address bits discarded
    cpu_adr = 16'hF7FF; cpu_dout = 8'h5A;
    cpu_mx = 1'b1; cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b1;
    #1 check("wr_wait_c0", cpu_wait_n, 0);
    check("wr_we_c0", ram_we, 0);
    tick();
    check("wr_we_c1", ram_we, 1);
    check("wr_adr_c1", ram_adr, 32'h7FF);
    check("wr_data_c1", ram_wdata, 32'h5A);
    tick();
    check("wr_we_c2", ram_we, 0);
    check("wr_wait_c2", cpu_wait_n, 1);
    for (int i = 0; i < 4; i++) tick();
    check("wr_single", wr_cnt, 1);
    check("wr_mem", mem[11'h7FF], 32'h5A);
    check("wr_wait_hold", cpu_wait_n, 1);
    cpu_idle();
    tick();
    cpu_read("rd7ff", 16'h07FF, 8'h5A);

    // Simultaneous: video first, CPU in the next free slot
    vid_req = 1'b1; vid_adr = 11'h010;
    cpu_adr = 16'h0020; cpu_mx = 1'b1; cpu_cs = 1'b1; cpu_rd = 1'b1;
    #1 check("sim_wait_c0", cpu_wait_n, 0);
    tick();
    check("sim_adr_c1", ram_adr, 32'h010);
    check("sim_ack_c1", vid_ack, 0);
    tick();
    check("sim_ack_c2", vid_ack, 0);
    check("sim_wait_c2", cpu_wait_n, 0);
    tick();
    check("sim_ack_c3", vid_ack, 1);
    check("sim_vdata_c3", vid_data, 32'h11);
    check("sim_adr_c3", ram_adr, 32'h020);
    check("sim_wait_c3", cpu_wait_n, 0);
    vid_req = 1'b0;
    tick();
    check("sim_ack_c4", vid_ack, 0);
    check("sim_wait_c4", cpu_wait_n, 0);
    tick();
    check("sim_wait_c5", cpu_wait_n, 1);
    check("sim_din_c5", cpu_din, 32'h22);
    cpu_idle();
    tick();

    // Non-window access alongside a video fetch
    vid_req = 1'b1; vid_adr = 11'h030;
    cpu_adr = 16'h0123; cpu_mx = 1'b1; cpu_cs = 1'b0; cpu_rd = 1'b1;
    #1 check("nw_wait_c0", cpu_wait_n, 1);
    tick();
    check("nw_adr_c1", ram_adr, 32'h030);
    tick(); tick();
    check("nw_ack_c3", vid_ack, 1);
    check("nw_vdata_c3", vid_data, 32'h33);
    vid_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("nw_wait_hold", cpu_wait_n, 1);
    check("nw_adr_hold", ram_adr, 32'h030);
    check("nw_din_hold", cpu_din, 32'h22);
    cpu_idle();
    tick();

    // Video held high continuously; CPU must still be served within the bound
    vid_req = 1'b1; vid_adr = 11'h040;
    tick(); tick();
    cpu_adr = 16'h0123; cpu_mx = 1'b1; cpu_cs = 1'b1; cpu_rd = 1'b1;
    begin
      int n = 0;
      #1;
      while (cpu_wait_n === 1'b0 && n < 30) begin
        tick();
        n++;
      end
      check("stv_bound", (n >= 3 && n <= 14) ? 1 : 0, 1);
      check("stv_din", cpu_din, 32'hA5);
    end
    cpu_idle();
    begin
      int a0 = ack_cnt;
      for (int i = 0; i < 10; i++) tick();
      check("stv_vid_resume", (ack_cnt > a0) ? 1 : 0, 1);
    end
    vid_req = 1'b0;
    tick(); tick(); tick();

    // Reset asserted while the write strobe is up
    mem[11'h100] = 8'h00;
    cpu_adr = 16'h0100; cpu_dout = 8'h77;
    cpu_mx = 1'b1; cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_rd = 1'b0;
    tick();
    check("rw_we_c1", ram_we, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rw_we_async", ram_we, 0);
    check("rw_wait_async", cpu_wait_n, 1);
    check("rw_adr_async", ram_adr, 0);
    cpu_idle();
    tick();
    reset_n = 1'b1;
    tick();
    check("rw_mem_kept", mem[11'h100], 32'h00);
    check("rw_din_reset", cpu_din, 0);
    cpu_read("rw_after", 16'h07FF, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/z80_vram_arbiter.md
Name: z80_vram_arbiter

Overview:
- Shares one single-port synchronous VRAM between the Z80 core wrapper and the video fetch engine.
- Video normally has priority. A CPU access to the VRAM window stalls the CPU through `wait_n` until its cycle is served.
- An anti-starvation counter guarantees the CPU a slot after a bounded wait.
- Sits between the Z80 wrapper's `adr`/`mx`/`rd`/`wr`/`data_*`/`wait_n` pins and the tile/sprite fetchers.

Parameters:
- AW, 11, VRAM address width (words of 8 bits).
- MAXWAIT, 8, clk cycles a pending CPU request may be denied before it gains priority over video.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_adr  in  16  Z80 address
- cpu_mx  in  1  Z80 memory request (refresh excluded)
- cpu_rd  in  1  Z80 read strobe
- cpu_wr  in  1  Z80 write strobe
- cpu_cs  in  1  address decode: cpu_adr is inside the VRAM window
- cpu_dout  in  8  Z80 write data
- cpu_din  out  8  read data returned to Z80
- cpu_wait_n  out  1  to Z80 WAIT_n; low stalls the CPU
- vid_req  in  1  video fetch request (level, held until vid_ack)
- vid_adr  in  AW  video fetch address
- vid_ack  out  1  one-cycle pulse: vid_data valid this cycle
- vid_data  out  8  video read data
- ram_adr  out  AW  VRAM address
- ram_we  out  1  VRAM write enable
- ram_wdata  out  8  VRAM write data
- ram_rdata  in  8  VRAM read data, valid one clk after address

Behaviour:
- Reset values (async on reset_n low): state=IDLE, cpu_wait_n=1, cpu_din=0, vid_ack=0, vid_data=0, ram_adr=0, ram_we=0, ram_wdata=0, starve counter=0, served flag=0.
- cpu_pend = cpu_mx & cpu_cs & (cpu_rd | cpu_wr) & ~served.
- cpu_wait_n = ~cpu_pend, combinational from inputs, so the CPU stalls in the same cycle it asserts. It returns high in the DONE cycle via served.
- States:
  - IDLE: choose a grant.
  - VID: one cycle.
  - CRD: one cycle.
  - CWR: one cycle.
  - DONE: one cycle.
- Grant in IDLE:
  - starve ≥ MAXWAIT and cpu_pend → CPU.
  - else vid_req → VID.
  - else cpu_pend → CPU.
  - else stay in IDLE.
- VID: drive ram_adr=vid_adr, ram_we=0. Next cycle latch vid_data=ram_rdata and pulse vid_ack=1. Return to IDLE. Video read latency is 2 clk from grant.
- CRD: ram_adr=cpu_adr[AW-1:0]. Next cycle latch cpu_din=ram_rdata, set served=1, go to DONE.
- CWR: ram_adr=cpu_adr[AW-1:0], ram_wdata=cpu_dout, ram_we=1 for exactly one clk. Set served=1, go to DONE.
- If cpu_rd and cpu_wr are both high, the access is treated as a write.
- DONE: cpu_wait_n=1. Go to IDLE.
- served clears when cpu_mx falls. One Z80 bus cycle therefore produces at most one RAM access.
- cpu_din holds its value until the next CPU read completes.
- Starve counter:
  - Increments each clk while cpu_pend is high and the CPU is not granted; saturates at MAXWAIT.
  - Clears when the CPU is granted.
  - Priority then reverts to video for the next grant.
- vid_req dropped before grant: no access, no ack. vid_req must not drop after grant; if it does, the ack is still issued.
- cpu_mx dropping mid-access (e.g. CPU reset): the in-flight RAM cycle completes, served clears, and no retry occurs.
- Address wrap: only cpu_adr[AW-1:0] is used; cpu_cs handles window decode.
- reset_n asserted mid-operation: all state returns to reset values immediately. ram_we deasserts asynchronously.

Test Plan:
- CPU read, video idle: preload VRAM[0x123]=0xA5; CPU reads 0x123 with cpu_cs=1 → cpu_wait_n low in cycle 0, CRD at cycle 1, cpu_din=0xA5 and cpu_wait_n high at cycle 3; exactly one RAM read.
- CPU write: write 0x5A to 0x7FF → ram_we high for exactly one clk with ram_adr=0x7FF, ram_wdata=0x5A; readback returns 0x5A; no second write while cpu_mx stays high.
- Simultaneous requests: vid_req (adr 0x010) and CPU read (0x020) in the same cycle → video served first, vid_ack 2 clk after grant; CPU served next; cpu_wait_n held low until then.
- Starvation: vid_req held high continuously, MAXWAIT=8, CPU read pending → CPU granted no later than 8 clk plus one in-flight video cycle after cpu_pend; counter resets; video resumes.
- Non-window access: cpu_mx=1, cpu_cs=0 → cpu_wait_n stays 1, no RAM access, video unaffected.
- Reset mid-write: assert reset_n=0 during CWR → ram_we=0 and cpu_wait_n=1 immediately, state IDLE after release, VRAM content unchanged apart from any edge already captured.
